// File: rtl/lcd_ctrl.sv
// lcd_ctrl: memory-mapped HD44780-style character LCD sequencer.
// CPU stores land in a small command FIFO; a timer-driven FSM replays each
// word on lcd_data and generates setup, enable pulse, hold and execution
// wait in hardware.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   wr_en     push request
//   wr_data   {RS, RW, DB[7:0]} word to push
//   full      FIFO holds FIFO_DEPTH entries
//   busy      FIFO non-empty or FSM not idle
//   overflow  sticky: a push was dropped
//   ovf_clr   synchronous clear for overflow
//   lcd_data  registered {RS, RW, DB} to the panel
//   lcd_en    registered panel enable strobe
module lcd_ctrl #(
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned SETUP_CYCLES     = 2,
  parameter int unsigned PULSE_CYCLES     = 12,
  parameter int unsigned HOLD_CYCLES      = 2,
  parameter int unsigned EXEC_CYCLES      = 50,
  parameter int unsigned LONG_EXEC_CYCLES = 2000,
  parameter int unsigned POWERON_CYCLES   = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [9:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [9:0] lcd_data,
  output logic       lcd_en
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned MAXC = max2(max2(max2(SETUP_CYCLES, PULSE_CYCLES),
                                           max2(HOLD_CYCLES, EXEC_CYCLES)),
                                      max2(LONG_EXEC_CYCLES, POWERON_CYCLES));
  localparam int unsigned TW   = $clog2(MAXC) + 1;

  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_HOLD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] T_EXEC  = TW'(EXEC_CYCLES - 1);
  localparam logic [TW-1:0] T_LONG  = TW'(LONG_EXEC_CYCLES - 1);
  localparam logic [TW-1:0] T_PON   = TW'(POWERON_CYCLES - 1);

  localparam logic [2:0] ST_POWERON = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_SETUP   = 3'd2;
  localparam logic [2:0] ST_PULSE   = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_EXEC    = 3'd5;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    lcd_data_q, lcd_data_d;
  logic          lcd_en_q, lcd_en_d;

  logic push, pop, drop, long_cmd;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign busy     = (count_q != '0) || (state_q != ST_IDLE);
  assign overflow = overflow_q;
  assign lcd_data = lcd_data_q;
  assign lcd_en   = lcd_en_q;

  // full is judged on the registered count, so a same-cycle pop never
  // rescues a push into a full FIFO.
  assign push = wr_en && !full;
  assign drop = wr_en && full;
  assign pop  = (state_q == ST_IDLE) && (count_q != '0);

  // Clear display (01) and return home (02/03) need the long execution wait.
  assign long_cmd = (lcd_data_q[9:8] == 2'b00) &&
                    ((lcd_data_q[7:0] == 8'h01) || (lcd_data_q[7:0] == 8'h02) ||
                     (lcd_data_q[7:0] == 8'h03));

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = wr_data;
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    lcd_data_d = lcd_data_q;
    lcd_en_d   = lcd_en_q;
    case (state_q)
      // Power-on wait counts up from the cleared reset value; every other
      // state loads its length minus one and counts down to zero.
      ST_POWERON: begin
        lcd_en_d = 1'b0;
        if (timer_q == T_PON) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pop) begin
          lcd_data_d = mem_q[rptr_q];
          state_d    = ST_SETUP;
          timer_d    = T_SETUP;
        end
      end
      ST_SETUP: begin
        if (timer_q == '0) begin
          state_d  = ST_PULSE;
          lcd_en_d = 1'b1;
          timer_d  = T_PULSE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (timer_q == '0) begin
          state_d  = ST_HOLD;
          lcd_en_d = 1'b0;
          timer_d  = T_HOLD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (timer_q == '0) begin
          state_d = ST_EXEC;
          timer_d = long_cmd ? T_LONG : T_EXEC;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_EXEC: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d  = ST_POWERON;
        timer_d  = '0;
        lcd_en_d = 1'b0;
      end
    endcase
  end

  // Storage needs no reset: the count/pointers define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_POWERON;
      timer_q    <= '0;
      lcd_data_q <= '0;
      lcd_en_q   <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      lcd_data_q <= lcd_data_d;
      lcd_en_q   <= lcd_en_d;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed self-checking bench for lcd_ctrl at default
// parameters. A monitor records enable-pulse rise times, pulse widths and
// the word presented at each rise, and flags any lcd_data change while
// lcd_en is high or inside the hold window.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [9:0] wr_data = '0;
  logic       ovf_clr = 1'b0;
  logic       full, busy, overflow, lcd_en;
  logic [9:0] lcd_data;

  lcd_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .busy     (busy),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .lcd_data (lcd_data),
    .lcd_en   (lcd_en)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: cyc counts rising edges; samples are taken 1 time unit later.
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic en_p = 1'b0;
  logic [9:0] d_p = '0;
  int   last_rise = 0;
  int   hold_left = 0;
  int   viol = 0;
  int   rise_t[$];
  int   rise_d[$];
  int   widths[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mon_en) begin
      if (lcd_en && !en_p) begin
        rise_t.push_back(cyc);
        rise_d.push_back(int'(lcd_data));
        last_rise = cyc;
      end
      if (!lcd_en && en_p) widths.push_back(cyc - last_rise);
      if ((lcd_data != d_p) && (en_p || lcd_en || hold_left > 0)) viol++;
      if (!lcd_en && en_p) hold_left = 2;
      else if (hold_left > 0) hold_left--;
    end
    en_p = lcd_en;
    d_p  = lcd_data;
  end

  function automatic int rt(input int k);
    return (k < rise_t.size()) ? rise_t[k] : -1;
  endfunction
  function automatic int rd(input int k);
    return (k < rise_d.size()) ? rise_d[k] : -1;
  endfunction
  function automatic int wd(input int k);
    return (k < widths.size()) ? widths[k] : -1;
  endfunction

  task automatic clear_mon();
    rise_t.delete();
    rise_d.delete();
    widths.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [9:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) tick();
  endtask

  int cyc0, e;
  bit seen_3ff;

  initial begin
    // Reset state.
    repeat (3) tick();
    check("rst_full", full, 0);
    check("rst_busy", busy, 1);
    check("rst_ovf", overflow, 0);
    check("rst_data", lcd_data, 10'h000);
    check("rst_en", lcd_en, 0);

    // 1: push during POWERON; first pulse waits out the power-on delay.
    reset  = 1'b1;
    mon_en = 1'b1;
    clear_mon();
    cyc0 = cyc;
    push(10'h038);
    check("t1_busy", busy, 1);
    check("t1_full", full, 0);
    for (int i = 0; i < 1100 && rise_t.size() == 0; i++) tick();
    check("t1_rise_time", rt(0) - cyc0, 1003);
    check("t1_data", rd(0), 10'h038);
    wait_idle(200);
    check("t1_idle_time", cyc - cyc0, 1067);
    check("t1_width", wd(0), 12);
    check("t1_en_low", lcd_en, 0);

    // 2: three words back-to-back.
    clear_mon();
    push(10'h038);
    push(10'h20F);
    push(10'h241);
    wait_idle(400);
    check("t2_pulses", rise_t.size(), 3);
    check("t2_gap01", rt(1) - rt(0), 67);
    check("t2_gap12", rt(2) - rt(1), 67);
    check("t2_d0", rd(0), 10'h038);
    check("t2_d1", rd(1), 10'h20F);
    check("t2_d2", rd(2), 10'h241);
    for (int k = 0; k < 3; k++) check("t2_width", wd(k), 12);

    // 3: clear command takes the long execution wait.
    clear_mon();
    push(10'h001);
    push(10'h241);
    wait_idle(2300);
    check("t3_pulses", rise_t.size(), 2);
    check("t3_gap", rt(1) - rt(0), 2017);
    check("t3_d1", rd(1), 10'h241);

    // 4: overflow while the FSM sits in EXEC.
    clear_mon();
    push(10'h038);
    repeat (20) tick();
    push(10'h241);
    push(10'h242);
    push(10'h243);
    check("t4_full_3", full, 0);
    push(10'h244);
    check("t4_full_4", full, 1);
    check("t4_ovf_4", overflow, 0);
    push(10'h245);
    check("t4_ovf_5", overflow, 1);
    check("t4_full_5", full, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", overflow, 0);
    wait_idle(500);
    check("t4_pulses", rise_t.size(), 5);
    for (int k = 1; k < 5; k++) check("t4_word", rd(k), 10'h240 + k);

    // 5: push into a full FIFO on the very edge the FSM pops.
    clear_mon();
    push(10'h038);
    e = cyc;             // pop at e+1, next pop at e+68
    repeat (20) tick();
    push(10'h241);
    push(10'h242);
    push(10'h243);
    push(10'h244);
    while (cyc < e + 67) tick();
    check("t5_full_pre", full, 1);
    check("t5_ovf_pre", overflow, 0);
    push(10'h3FF);
    check("t5_full_post", full, 0);
    check("t5_ovf_post", overflow, 1);
    wait_idle(500);
    check("t5_pulses", rise_t.size(), 5);
    seen_3ff = 1'b0;
    foreach (rise_d[k]) if (rise_d[k] == 10'h3FF) seen_3ff = 1'b1;
    check("t5_no_dropped", seen_3ff, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    check("data_stable", viol, 0);

    // 6: reset in the middle of a pulse with two words queued.
    clear_mon();
    push(10'h038);
    e = cyc;
    push(10'h241);
    push(10'h242);
    while (cyc < e + 8) tick();
    check("t6_en_before", lcd_en, 1);
    mon_en = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("t6_en_async", lcd_en, 0);
    check("t6_full_async", full, 0);
    check("t6_data_async", lcd_data, 10'h000);
    check("t6_busy_async", busy, 1);
    tick();
    reset  = 1'b1;
    clear_mon();
    mon_en = 1'b1;
    repeat (1100) tick();
    check("t6_no_stale", rise_t.size(), 0);
    check("t6_idle", busy, 0);
    check("t6_data_kept", lcd_data, 10'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
